// File: rtl/uart_receiver.sv
// UART receiver: oversampled start/data/stop framing on a synchronised rx line.
// The receiver samples each bit at its centre. It reports a good frame with rx_done.
// It reports a low stop bit with frame_error, then waits for the line to go idle.
module uart_receiver #(
    parameter int SAMPLE    = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_done,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int SW = $clog2(SAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [SW-1:0] S_HALF = SW'(SAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 state_reg, state_next;
    logic [SW-1:0]          s_cnt_reg, s_cnt_next;
    logic [BW-1:0]          b_cnt_reg, b_cnt_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [DATA_BITS-1:0]   data_out_reg, data_out_next;
    logic                   rx_done_reg, rx_done_next;
    logic                   frame_error_reg, frame_error_next;
    logic                   rx_meta_reg;
    logic                   rx_s_reg;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // State, counters, shift register and registered output pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            s_cnt_reg       <= '0;
            b_cnt_reg       <= '0;
            shift_reg       <= '0;
            data_out_reg    <= '0;
            rx_done_reg     <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            s_cnt_reg       <= s_cnt_next;
            b_cnt_reg       <= b_cnt_next;
            shift_reg       <= shift_next;
            data_out_reg    <= data_out_next;
            rx_done_reg     <= rx_done_next;
            frame_error_reg <= frame_error_next;
        end
    end

    // Next-state logic. Everything except the IDLE start detection advances only on a tick.
    always_comb begin
        state_next       = state_reg;
        s_cnt_next       = s_cnt_reg;
        b_cnt_next       = b_cnt_reg;
        shift_next       = shift_reg;
        data_out_next    = data_out_reg;
        rx_done_next     = 1'b0;
        frame_error_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rx_s_reg) begin
                    state_next = START;
                    s_cnt_next = '0;
                end
            end

            START: begin
                if (sample_clk) begin
                    if (s_cnt_reg == S_HALF) begin
                        s_cnt_next = '0;
                        if (!rx_s_reg) begin
                            state_next = DATA;
                            b_cnt_next = '0;
                        end else begin
                            // Line went back high before mid start bit: a glitch.
                            state_next = IDLE;
                        end
                    end else begin
                        s_cnt_next = s_cnt_reg + SW'(1);
                    end
                end
            end

            DATA: begin
                if (sample_clk) begin
                    if (s_cnt_reg == S_LAST) begin
                        s_cnt_next = '0;
                        // LSB arrives first, so shift right and insert at the top.
                        shift_next = {rx_s_reg, shift_reg[DATA_BITS-1:1]};
                        if (b_cnt_reg == B_LAST) begin
                            state_next = STOP;
                        end else begin
                            b_cnt_next = b_cnt_reg + BW'(1);
                        end
                    end else begin
                        s_cnt_next = s_cnt_reg + SW'(1);
                    end
                end
            end

            STOP: begin
                if (sample_clk) begin
                    if (s_cnt_reg == S_LAST) begin
                        s_cnt_next = '0;
                        if (rx_s_reg) begin
                            data_out_next = shift_reg;
                            rx_done_next  = 1'b1;
                            state_next    = IDLE;
                        end else begin
                            frame_error_next = 1'b1;
                            state_next       = WAIT_HIGH;
                        end
                    end else begin
                        s_cnt_next = s_cnt_reg + SW'(1);
                    end
                end
            end

            WAIT_HIGH: begin
                // Hold off while the line is broken so a long low doesn't look like a start.
                if (sample_clk && rx_s_reg) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign data_out    = data_out_reg;
    assign rx_done     = rx_done_reg;
    assign frame_error = frame_error_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver: drives serial frames tick-aligned.
// It compares received bytes, pulses and timing against a frame-level model.
module tb_uart_receiver;

    localparam int SAMPLE    = 16;
    localparam int DATA_BITS = 8;
    localparam int TICK_DIV  = 6;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 sample_clk = 1'b0;
    logic                 rx = 1'b1;
    logic [DATA_BITS-1:0] data_out;
    logic                 rx_done;
    logic                 frame_error;
    logic                 busy;

    int checks = 0;
    int failures = 0;

    bit          tick_en = 1'b1;
    int unsigned tick_cnt = 0;

    logic [DATA_BITS-1:0] done_q[$];
    int unsigned          done_tick_q[$];
    int                   fe_cnt = 0;
    int                   overlap_cnt = 0;

    uart_receiver #(
        .SAMPLE   (SAMPLE),
        .DATA_BITS(DATA_BITS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_clk (sample_clk),
        .rx         (rx),
        .data_out   (data_out),
        .rx_done    (rx_done),
        .frame_error(frame_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Tick generator: one-clk enable every TICK_DIV clocks, changed on the falling edge.
    initial begin : tick_gen
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                c = (c + 1) % TICK_DIV;
                sample_clk = (c == 0);
            end else begin
                sample_clk = 1'b0;
            end
        end
    end

    // Global tick count, used to time rx_done relative to the start edge.
    always @(posedge clk) begin
        if (sample_clk) tick_cnt++;
    end

    // Output monitor: record every rx_done byte and every frame_error pulse.
    always @(negedge clk) begin
        if (rx_done) begin
            done_q.push_back(data_out);
            done_tick_q.push_back(tick_cnt);
        end
        if (frame_error) fe_cnt++;
        if (rx_done && frame_error) overlap_cnt++;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic wait_tick();
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            guard++;
        end while (!sample_clk && guard < 1000);
        if (guard >= 1000) begin
            checks++;
            failures++;
            $display("FAIL wait_tick: no tick within 1000 clk, required a tick");
        end
    endtask

    task automatic send_bit(input logic v);
        @(negedge clk);
        rx = v;
        repeat (SAMPLE) wait_tick();
    endtask

    // One full frame: start bit, LSB-first data, stop bit of the given level.
    task automatic send_frame(input logic [DATA_BITS-1:0] b, input logic stop_v, output int unsigned t0);
        @(negedge clk);
        rx = 1'b0;
        t0 = tick_cnt;
        repeat (SAMPLE) wait_tick();
        for (int i = 0; i < DATA_BITS; i++) send_bit(b[i]);
        send_bit(stop_v);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out: got %h required 00", data_out); end
        checks++;
        if (rx_done !== 1'b0) begin failures++; $display("FAIL reset_rx_done: got %b required 0", rx_done); end
        checks++;
        if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_frame_error: got %b required 0", frame_error); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2 * SAMPLE) wait_tick();
        $display("reset: data_out=%h busy=%b", data_out, busy);
    endtask

    task automatic test_nominal();
        int unsigned     t0;
        int unsigned     dt;
        int              fe0;
        logic [DATA_BITS-1:0] got;
        done_q.delete();
        done_tick_q.delete();
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b1, t0);
        send_bit(1'b1);
        checks++;
        if (done_q.size() != 1) begin failures++; $display("FAIL nominal_pulses: got %0d rx_done required 1", done_q.size()); end
        got = (done_q.size() > 0) ? done_q[0] : 'x;
        checks++;
        if (got !== 8'h55) begin failures++; $display("FAIL nominal_data: got %h required 55", got); end
        dt = (done_tick_q.size() > 0) ? done_tick_q[0] - t0 : 0;
        checks++;
        if (dt < SAMPLE * 9 + SAMPLE / 2 - 1 || dt > SAMPLE * 9 + SAMPLE / 2 + 1) begin
            failures++;
            $display("FAIL nominal_timing: got %0d ticks required %0d", dt, SAMPLE * 9 + SAMPLE / 2);
        end
        checks++;
        if (fe_cnt != fe0) begin failures++; $display("FAIL nominal_no_fe: got %0d frame_error required 0", fe_cnt - fe0); end
        $display("nominal: byte=55 got=%h ticks=%0d", got, dt);
    endtask

    task automatic test_glitch();
        logic [DATA_BITS-1:0] prev;
        int fe0;
        prev = data_out;
        fe0 = fe_cnt;
        done_q.delete();
        @(negedge clk);
        rx = 1'b0;
        repeat (4) wait_tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_during: got %b required 1", busy); end
        @(negedge clk);
        rx = 1'b1;
        repeat (2 * SAMPLE) wait_tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL glitch_idle: got busy=%b required 0", busy); end
        checks++;
        if (done_q.size() != 0 || fe_cnt != fe0) begin
            failures++;
            $display("FAIL glitch_pulses: got rx_done=%0d frame_error=%0d required 0 0", done_q.size(), fe_cnt - fe0);
        end
        checks++;
        if (data_out !== prev) begin failures++; $display("FAIL glitch_data: got %h required %h", data_out, prev); end
        $display("glitch: busy=%b data_out=%h", busy, data_out);
    endtask

    task automatic test_frame_error();
        logic [DATA_BITS-1:0] prev;
        int unsigned t0;
        int fe0;
        prev = data_out;
        fe0 = fe_cnt;
        done_q.delete();
        send_frame(8'hA3, 1'b0, t0);
        repeat (2 * SAMPLE) wait_tick();
        checks++;
        if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL ferr_pulse: got %0d frame_error required 1", fe_cnt - fe0); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL ferr_wait_high: got busy=%b required 1", busy); end
        checks++;
        if (done_q.size() != 0) begin failures++; $display("FAIL ferr_no_done: got %0d rx_done required 0", done_q.size()); end
        checks++;
        if (data_out !== prev) begin failures++; $display("FAIL ferr_data: got %h required %h", data_out, prev); end
        @(negedge clk);
        rx = 1'b1;
        repeat (SAMPLE) wait_tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL ferr_release: got busy=%b required 0", busy); end
        checks++;
        if (fe_cnt - fe0 != 1 || done_q.size() != 0) begin
            failures++;
            $display("FAIL ferr_after_release: got frame_error=%0d rx_done=%0d required 1 0", fe_cnt - fe0, done_q.size());
        end
        $display("frame_error: byte=A3 stop=0 fe=%0d data_out=%h", fe_cnt - fe0, data_out);
    endtask

    task automatic test_back_to_back();
        int unsigned t0;
        logic [DATA_BITS-1:0] exp_b[2];
        exp_b[0] = 8'hA3;
        exp_b[1] = 8'h0F;
        done_q.delete();
        send_frame(exp_b[0], 1'b1, t0);
        send_frame(exp_b[1], 1'b1, t0);
        send_bit(1'b1);
        checks++;
        if (done_q.size() != 2) begin failures++; $display("FAIL b2b_pulses: got %0d rx_done required 2", done_q.size()); end
        for (int i = 0; i < 2; i++) begin
            logic [DATA_BITS-1:0] got;
            got = (done_q.size() > i) ? done_q[i] : 'x;
            checks++;
            if (got !== exp_b[i]) begin failures++; $display("FAIL b2b_data%0d: got %h required %h", i, got, exp_b[i]); end
            $display("back_to_back: frame %0d byte=%h got=%h", i, exp_b[i], got);
        end
    endtask

    task automatic test_random();
        logic [DATA_BITS-1:0] exp_q[$];
        int unsigned t0;
        int fe0;
        fe0 = fe_cnt;
        done_q.delete();
        for (int n = 0; n < 12; n++) begin
            logic [DATA_BITS-1:0] b;
            int gap;
            b = DATA_BITS'($urandom);
            gap = $urandom_range(0, 2);
            send_frame(b, 1'b1, t0);
            exp_q.push_back(b);
            repeat (gap) send_bit(1'b1);
        end
        send_bit(1'b1);
        checks++;
        if (done_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count: got %0d rx_done required %0d", done_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [DATA_BITS-1:0] got;
            got = (done_q.size() > i) ? done_q[i] : 'x;
            checks++;
            if (got !== exp_q[i]) begin failures++; $display("FAIL random_data%0d: got %h required %h", i, got, exp_q[i]); end
            $display("random: frame %0d byte=%h got=%h", i, exp_q[i], got);
        end
        checks++;
        if (fe_cnt != fe0) begin failures++; $display("FAIL random_no_fe: got %0d frame_error required 0", fe_cnt - fe0); end
    endtask

    task automatic test_stall();
        logic [DATA_BITS-1:0] b;
        logic [DATA_BITS-1:0] got;
        int fe0;
        b = 8'hC6;
        fe0 = fe_cnt;
        done_q.delete();
        @(negedge clk);
        rx = 1'b0;
        repeat (SAMPLE) wait_tick();
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        @(negedge clk);
        rx = b[4];
        repeat (SAMPLE / 2) wait_tick();
        tick_en = 1'b0;
        // Wiggle the line while ticks are stopped; nothing may be sampled.
        repeat (300) @(negedge clk);
        rx = ~b[4];
        repeat (400) @(negedge clk);
        rx = b[4];
        repeat (300) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy: got %b required 1", busy); end
        checks++;
        if (done_q.size() != 0 || fe_cnt != fe0) begin
            failures++;
            $display("FAIL stall_frozen: got rx_done=%0d frame_error=%0d required 0 0", done_q.size(), fe_cnt - fe0);
        end
        tick_en = 1'b1;
        repeat (SAMPLE - SAMPLE / 2) wait_tick();
        for (int i = 5; i < DATA_BITS; i++) send_bit(b[i]);
        send_bit(1'b1);
        send_bit(1'b1);
        got = (done_q.size() > 0) ? done_q[0] : 'x;
        checks++;
        if (done_q.size() != 1 || got !== b) begin
            failures++;
            $display("FAIL stall_resume: got %0d pulses data %h required 1 pulse data %h", done_q.size(), got, b);
        end
        $display("stall: byte=%h got=%h", b, got);
    endtask

    task automatic test_reset_mid();
        int unsigned t0;
        logic [DATA_BITS-1:0] got;
        done_q.delete();
        @(negedge clk);
        rx = 1'b0;
        repeat (SAMPLE) wait_tick();
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        @(negedge clk);
        rx = 1'b1;
        repeat (SAMPLE / 2) wait_tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before: got %b required 1", busy); end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (data_out !== 8'h00 || rx_done !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_outputs: got data=%h done=%b fe=%b busy=%b required 00 0 0 0",
                     data_out, rx_done, frame_error, busy);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2 * SAMPLE) wait_tick();
        send_frame(8'h3C, 1'b1, t0);
        send_bit(1'b1);
        got = (done_q.size() > 0) ? done_q[0] : 'x;
        checks++;
        if (done_q.size() != 1 || got !== 8'h3C) begin
            failures++;
            $display("FAIL rstmid_next_frame: got %0d pulses data %h required 1 pulse data 3c", done_q.size(), got);
        end
        $display("reset_mid: next byte=3c got=%h", got);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_random();
        test_stall();
        test_reset_mid();
        checks++;
        if (overlap_cnt != 0) begin failures++; $display("FAIL pulse_overlap: got %0d overlaps required 0", overlap_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
